bist_response_checker: RTL

Read-side response checker for the MBIST engine. While the address counter walks the array and issues reads, this block aligns each read's expected pattern with the memory's read data after the configured read latency. It compares the two bitwise and accumulates pass/fail status and a saturating fail count. It also optionally captures first-fail diagnostics for the BIST controller and scan-out.

---
 rtl/bist_pkg.sv | 27 ++
 rtl/bist_rd_pipe.sv | 42 ++++
 rtl/bist_response_checker.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared MBIST checker types, latency limits and the fail-count saturation helper.
// Used by bist_response_checker and bist_rd_pipe.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } chk_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  localparam int CNT_W_MAX  = 32;

  // True when a w-bit counter (zero-extended to 32 bits) is at all-ones.
  function automatic logic cnt_at_max(
    input logic [31:0] cnt,
    input int          w
  );
    logic [31:0] top;
    top = (w >= 32) ? 32'hFFFF_FFFF
                    : ((32'd1 << w) - 32'd1);
    return (cnt == top);
  endfunction

endpackage

// File: rtl/bist_rd_pipe.sv
// Valid-tagged read delay line; stage 0 always loads the push so a read
// issued with a flush survives as the first entry of the new test.
module bist_rd_pipe #(
  parameter int DEPTH = 1,
  parameter int PAY_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [PAY_W-1:0] push_data,
  output logic             out_valid,
  output logic [PAY_W-1:0] out_data,
  output logic             any_valid
);

  logic [DEPTH-1:0] vld;
  logic [PAY_W-1:0] pay [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
    end else begin
      vld[0] <= push;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= flush ? 1'b0 : vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    pay[0] <= push_data;
    for (int i = 1; i < DEPTH; i++) begin
      pay[i] <= pay[i-1];
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = pay[DEPTH-1];
  assign any_valid = |vld;

endmodule

// File: rtl/bist_response_checker.sv
// MBIST read-response checker: aligns expected data with mem_q after RD_LAT.
// Define BIST_CHK_DIAG_EN to enable first-fail address and fail-bit capture.
module bist_response_checker
  import bist_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic [DATA_W-1:0] mem_q,
  input  logic              done_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [DATA_W-1:0] fail_bits
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_lat_chk
    $error("bist_response_checker: RD_LAT out of range");
  end
  if (CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_cnt_chk
    $error("bist_response_checker: CNT_W out of range");
  end

`ifdef BIST_CHK_DIAG_EN
  localparam int PAY_W = ADDR_W + DATA_W;
`else
  localparam int PAY_W = DATA_W;
`endif

  chk_state_e        state;
  logic              push;
  logic              out_valid;
  logic              any_valid;
  logic [PAY_W-1:0]  push_data;
  logic [PAY_W-1:0]  out_data;
  logic [DATA_W-1:0] out_exp;
  logic [DATA_W-1:0] syn;
  logic              miss;
  logic              cnt_sat;

  // start admits its own rd_en as the first read of the new test
  assign push = rd_en & (start | (state == RUN));

`ifdef BIST_CHK_DIAG_EN
  assign push_data = {rd_addr, exp_data};
`else
  assign push_data = exp_data;
`endif

  bist_rd_pipe #(
    .DEPTH (RD_LAT),
    .PAY_W (PAY_W)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .flush     (start),
    .push      (push),
    .push_data (push_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .any_valid (any_valid)
  );

  assign out_exp = out_data[DATA_W-1:0];
  assign syn     = mem_q ^ out_exp;
  assign miss    = out_valid & (|syn);
  assign cnt_sat = cnt_at_max(32'(fail_cnt), CNT_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      fail_cnt <= '0;
    end else if (start) begin
      state    <= RUN;
      busy     <= 1'b1;
      done     <= 1'b0;
      pass     <= 1'b0;
      fail     <= 1'b0;
      fail_cnt <= '0;
    end else begin
      if (miss) begin
        fail <= 1'b1;
        if (!cnt_sat) begin
          fail_cnt <= fail_cnt + CNT_W'(1);
        end
      end
      unique case (state)
        IDLE: ;
        RUN: begin
          if (done_in) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // empty pipe means no compare this edge, so fail is final
          if (!any_valid) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= ~fail;
          end
        end
        DONE: ;
      endcase
    end
  end

`ifdef BIST_CHK_DIAG_EN
  logic [ADDR_W-1:0] ffa_q;
  logic [DATA_W-1:0] fbits_q;
  logic [ADDR_W-1:0] out_addr;

  assign out_addr = out_data[PAY_W-1:DATA_W];

  always_ff @(posedge clk) begin
    if (reset || start) begin
      ffa_q   <= '0;
      fbits_q <= '0;
    end else if (miss) begin
      if (!fail) begin
        ffa_q <= out_addr;
      end
      fbits_q <= fbits_q | syn;
    end
  end

  assign first_fail_addr = ffa_q;
  assign fail_bits       = fbits_q;
`else
  logic unused_addr;

  assign unused_addr     = ^rd_addr;
  assign first_fail_addr = '0;
  assign fail_bits       = '0;
`endif

endmodule
